// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared types for the line/word datapath:
//   lc3b_word        - 16-bit machine word (default streamer output width)
//   lc3b_burst       - 128-bit cache line (default streamer input width)
//   streamer_state_e - line_word_streamer FSM state
//   idx_width()      - word-index width helper, never narrower than 1 bit
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_burst;

  localparam int unsigned LC3B_WORD_W  = $bits(lc3b_word);
  localparam int unsigned LC3B_BURST_W = $bits(lc3b_burst);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } streamer_state_e;

  // A one-word line still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned nwords);
    int unsigned w;
    w = $clog2(nwords);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/word_mux.sv
// ---------------------------------------------------------------------------
// word_mux
// Combinational selection of one WORD_WIDTH slice out of a line.
//   line  in  LINE_WIDTH  packed line, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   index in  IDX_W       word to select
//   word  out WORD_WIDTH  selected word
// ---------------------------------------------------------------------------
module word_mux
  import lc3b_types::*;
#(
  parameter  int unsigned LINE_WIDTH = LC3B_BURST_W,
  parameter  int unsigned WORD_WIDTH = LC3B_WORD_W,
  localparam int unsigned NWORDS     = LINE_WIDTH / WORD_WIDTH,
  localparam int unsigned IDX_W      = idx_width(NWORDS)
) (
  input  logic [LINE_WIDTH-1:0] line,
  input  logic [IDX_W-1:0]      index,
  output logic [WORD_WIDTH-1:0] word
);

  // Compare-and-select loop keeps every slice in range, including the
  // one-word case where the index bit has no matching word.
  always_comb begin
    word = '0;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (index == IDX_W'(k)) begin
        word = line[k*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        word = word;
      end
    end
  end

endmodule

// File: rtl/line_word_streamer.sv
// ---------------------------------------------------------------------------
// line_word_streamer
// Accepts one cache line and streams it out as NWORDS words, either
// critical-word-first with wrap-around (WRAP_MODE=1) or from word 0.
//   clk, rst_n  clock (rising) and asynchronous active-low reset
//   in_valid    line offered          in_ready  line can be accepted
//   in_line     line data             in_offset byte offset of requested word
//   abort       synchronous cancel of the current burst
//   out_valid   out_word valid        out_ready consumer accepts the word
//   out_word    current word          out_index word index within the line
//   out_last    final word of the burst
// ---------------------------------------------------------------------------
module line_word_streamer
  import lc3b_types::*;
#(
  parameter  int unsigned LINE_WIDTH = LC3B_BURST_W,
  parameter  int unsigned WORD_WIDTH = LC3B_WORD_W,
  parameter  int unsigned WRAP_MODE  = 1,
  localparam int unsigned NWORDS     = LINE_WIDTH / WORD_WIDTH,
  localparam int unsigned OFS_W      = $clog2(LINE_WIDTH / 8),
  localparam int unsigned IDX_W      = idx_width(NWORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LINE_WIDTH-1:0] in_line,
  input  logic [OFS_W-1:0]      in_offset,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last
);

  // Byte-offset bits below this position address bytes inside one word.
  localparam int unsigned WB       = $clog2(WORD_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 32'd1);

  streamer_state_e       state_r;
  logic [LINE_WIDTH-1:0] line_r;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      beat_r;
  logic                  out_valid_r;
  logic                  out_last_r;

  logic [IDX_W-1:0]      start_idx_s;
  logic [IDX_W-1:0]      idx_next_s;
  logic [IDX_W-1:0]      beat_inc_s;
  logic [WORD_WIDTH-1:0] word_s;

  assign in_ready  = (state_r == IDLE) && !abort;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_index = idx_r;
  assign out_word  = word_s;

  // Start word of a new burst; the shift drops the byte-within-word bits.
  always_comb begin
    if (WRAP_MODE != 32'd0) begin
      start_idx_s = IDX_W'(in_offset >> WB);
    end else begin
      start_idx_s = '0;
    end
  end

  // Index wraps explicitly so NWORDS need not fill the IDX_W range.
  always_comb begin
    beat_inc_s = beat_r + IDX_W'(1);
    if (idx_r == LAST_IDX) begin
      idx_next_s = '0;
    end else begin
      idx_next_s = idx_r + IDX_W'(1);
    end
  end

  // Word selection reads only the registered buffer and index, so nothing
  // on in_* reaches out_word combinationally.
  word_mux #(
    .LINE_WIDTH (LINE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_word_mux (
    .line  (line_r),
    .index (idx_r),
    .word  (word_s)
  );

  // Burst FSM: abort outranks both the accept and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      line_r      <= '0;
      idx_r       <= '0;
      beat_r      <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (abort) begin
      state_r     <= IDLE;
      beat_r      <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r     <= STREAM;
            line_r      <= in_line;
            idx_r       <= start_idx_s;
            beat_r      <= '0;
            out_valid_r <= 1'b1;
            out_last_r  <= (LAST_IDX == '0);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last_r) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else begin
              idx_r      <= idx_next_s;
              beat_r     <= beat_inc_s;
              out_last_r <= (beat_inc_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          beat_r      <= '0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_word_streamer.sv
// ---------------------------------------------------------------------------
// tb_line_word_streamer
// Directed bench for line_word_streamer: default wrap instance (a), linear
// instance (b), 64/32 instance (c) and a one-word-line instance (d).
// ---------------------------------------------------------------------------
module tb_line_word_streamer;

  localparam logic [127:0] LINE_A = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] LINE_B = 128'hB007_B006_B005_B004_B003_B002_B001_B000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  // instance a: defaults, wrap mode
  logic a_in_valid = 1'b0, a_in_ready, a_abort = 1'b0, a_out_valid, a_out_ready = 1'b1, a_out_last;
  logic [127:0] a_in_line = '0;
  logic [3:0]   a_in_offset = '0;
  logic [15:0]  a_out_word;
  logic [2:0]   a_out_index;

  // instance b: linear mode
  logic b_in_valid = 1'b0, b_in_ready, b_abort = 1'b0, b_out_valid, b_out_ready = 1'b1, b_out_last;
  logic [127:0] b_in_line = '0;
  logic [3:0]   b_in_offset = '0;
  logic [15:0]  b_out_word;
  logic [2:0]   b_out_index;

  // instance c: 64-bit line, 32-bit words
  logic c_in_valid = 1'b0, c_in_ready, c_abort = 1'b0, c_out_valid, c_out_ready = 1'b1, c_out_last;
  logic [63:0] c_in_line = '0;
  logic [2:0]  c_in_offset = '0;
  logic [31:0] c_out_word;
  logic [0:0]  c_out_index;

  // instance d: one word per line
  logic d_in_valid = 1'b0, d_in_ready, d_abort = 1'b0, d_out_valid, d_out_ready = 1'b1, d_out_last;
  logic [31:0] d_in_line = '0;
  logic [1:0]  d_in_offset = '0;
  logic [31:0] d_out_word;
  logic [0:0]  d_out_index;

  line_word_streamer #(.LINE_WIDTH(128), .WORD_WIDTH(16), .WRAP_MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_line(a_in_line), .in_offset(a_in_offset), .abort(a_abort),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_word(a_out_word),
    .out_index(a_out_index), .out_last(a_out_last));

  line_word_streamer #(.LINE_WIDTH(128), .WORD_WIDTH(16), .WRAP_MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_line(b_in_line), .in_offset(b_in_offset), .abort(b_abort),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_word(b_out_word),
    .out_index(b_out_index), .out_last(b_out_last));

  line_word_streamer #(.LINE_WIDTH(64), .WORD_WIDTH(32), .WRAP_MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_line(c_in_line), .in_offset(c_in_offset), .abort(c_abort),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_word(c_out_word),
    .out_index(c_out_index), .out_last(c_out_last));

  line_word_streamer #(.LINE_WIDTH(32), .WORD_WIDTH(32), .WRAP_MODE(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_line(d_in_line), .in_offset(d_in_offset), .abort(d_abort),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_word(d_out_word),
    .out_index(d_out_index), .out_last(d_out_last));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // run-away guard
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] stall_words [11];
    logic [2:0]  stall_idx   [11];
    stall_words = '{16'h3333, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 16'h5555,
                    16'h6666, 16'h7777, 16'h0000, 16'h1111, 16'h2222};
    stall_idx   = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

    // reset state
    #2;
    check_eq("rst_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_word",  64'(a_out_word),  64'd0);
    check_eq("rst_index", 64'(a_out_index), 64'd0);
    check_eq("rst_last",  64'(a_out_last),  64'd0);
    check_eq("rst_ready", 64'(a_in_ready),  64'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // critical-word-first burst, input changed after accept
    a_in_line = LINE_A; a_in_offset = 4'h6; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0; a_in_line = '1; a_in_offset = 4'h0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("wrap_valid%0d", i), 64'(a_out_valid), 64'd1);
      check_eq($sformatf("wrap_word%0d", i),  64'(a_out_word),  64'(16'((3 + i) % 8 * 16'h1111)));
      check_eq($sformatf("wrap_idx%0d", i),   64'(a_out_index), 64'((3 + i) % 8));
      check_eq($sformatf("wrap_last%0d", i),  64'(a_out_last),  64'(i == 7));
      check_eq($sformatf("wrap_rdy%0d", i),   64'(a_in_ready),  64'd0);
      step();
    end
    check_eq("wrap_end_valid", 64'(a_out_valid), 64'd0);
    check_eq("wrap_end_last",  64'(a_out_last),  64'd0);
    check_eq("wrap_end_word",  64'(a_out_word),  64'h2222);
    check_eq("wrap_end_idx",   64'(a_out_index), 64'd2);
    check_eq("wrap_end_rdy",   64'(a_in_ready),  64'd1);

    // backpressure on cycles 2-4
    a_in_line = LINE_A; a_in_offset = 4'h6; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      a_out_ready = !(c >= 1 && c <= 3);
      check_eq($sformatf("stall_valid%0d", c), 64'(a_out_valid), 64'd1);
      check_eq($sformatf("stall_word%0d", c),  64'(a_out_word),  64'(stall_words[c]));
      check_eq($sformatf("stall_idx%0d", c),   64'(a_out_index), 64'(stall_idx[c]));
      check_eq($sformatf("stall_last%0d", c),  64'(a_out_last),  64'(c == 10));
      step();
    end
    a_out_ready = 1'b1;
    check_eq("stall_end_valid", 64'(a_out_valid), 64'd0);

    // abort on beat 3 while a new line is offered
    a_in_line = LINE_A; a_in_offset = 4'h6; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    check_eq("abort_beat3_word", 64'(a_out_word), 64'h5555);
    a_abort = 1'b1; a_in_valid = 1'b1; a_in_line = LINE_B; a_in_offset = 4'h2;
    #1;
    check_eq("abort_in_ready", 64'(a_in_ready), 64'd0);
    step();
    check_eq("abort_valid", 64'(a_out_valid), 64'd0);
    check_eq("abort_last",  64'(a_out_last),  64'd0);
    check_eq("abort_word",  64'(a_out_word),  64'h5555);
    check_eq("abort_idx",   64'(a_out_index), 64'd5);
    a_abort = 1'b0;
    #1;
    check_eq("abort_rdy_after", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("newline_valid%0d", i), 64'(a_out_valid), 64'd1);
      check_eq($sformatf("newline_word%0d", i),  64'(a_out_word),  64'(16'hB000 | 16'((1 + i) % 8)));
      check_eq($sformatf("newline_idx%0d", i),   64'(a_out_index), 64'((1 + i) % 8));
      check_eq($sformatf("newline_last%0d", i),  64'(a_out_last),  64'(i == 7));
      step();
    end
    check_eq("newline_end_valid", 64'(a_out_valid), 64'd0);

    // linear mode ignores the offset
    b_in_line = LINE_A; b_in_offset = 4'hE; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("lin_word%0d", i), 64'(b_out_word),  64'(16'(i * 16'h1111)));
      check_eq($sformatf("lin_idx%0d", i),  64'(b_out_index), 64'(i));
      check_eq($sformatf("lin_last%0d", i), 64'(b_out_last),  64'(i == 7));
      check_eq($sformatf("lin_rdy%0d", i),  64'(b_in_ready),  64'd0);
      step();
    end
    check_eq("lin_end_valid", 64'(b_out_valid), 64'd0);

    // two-word line
    c_in_line = 64'hDDDD_CCCC_BBBB_AAAA; c_in_offset = 3'h4; c_in_valid = 1'b1;
    step();
    c_in_valid = 1'b0;
    check_eq("w32_word0", 64'(c_out_word),  64'hDDDDCCCC);
    check_eq("w32_idx0",  64'(c_out_index), 64'd1);
    check_eq("w32_last0", 64'(c_out_last),  64'd0);
    step();
    check_eq("w32_word1", 64'(c_out_word),  64'hBBBBAAAA);
    check_eq("w32_idx1",  64'(c_out_index), 64'd0);
    check_eq("w32_last1", 64'(c_out_last),  64'd1);
    step();
    check_eq("w32_end_valid", 64'(c_out_valid), 64'd0);

    // one-word line: single beat, last set
    d_in_line = 32'hCAFE_F00D; d_in_offset = 2'h3; d_in_valid = 1'b1;
    step();
    d_in_valid = 1'b0;
    check_eq("one_valid", 64'(d_out_valid), 64'd1);
    check_eq("one_word",  64'(d_out_word),  64'hCAFEF00D);
    check_eq("one_idx",   64'(d_out_index), 64'd0);
    check_eq("one_last",  64'(d_out_last),  64'd1);
    step();
    check_eq("one_end_valid", 64'(d_out_valid), 64'd0);

    // asynchronous reset in the middle of beat 5
    a_in_line = LINE_A; a_in_offset = 4'h6; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("pre_rst_word%0d", i), 64'(a_out_word), 64'(16'((3 + i) % 8 * 16'h1111)));
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check_eq("mid_rst_word",  64'(a_out_word),  64'd0);
    check_eq("mid_rst_idx",   64'(a_out_index), 64'd0);
    check_eq("mid_rst_last",  64'(a_out_last),  64'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("post_rst_valid%0d", i), 64'(a_out_valid), 64'd0);
      check_eq($sformatf("post_rst_rdy%0d", i),   64'(a_in_ready),  64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
